// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and sizing for the FIFO stream reader.
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = 2;

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// Two-entry output buffer; the head entry is a register so the stream word comes straight off a flop.
module fifo_stream_reader_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [OCC_W-1:0]  occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] second;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= '0;
            head   <= '0;
            second <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == '0) head <= din;
                    else           second <= din;
                    occ <= occ + OCC_W'(1);
                end
                2'b01: begin
                    head <= second;
                    occ  <= occ - OCC_W'(1);
                end
                // Simultaneous push and pop: occupancy holds, head advances in order.
                2'b11: begin
                    if (occ == OCC_W'(1)) begin
                        head <= din;
                    end else begin
                        head   <= second;
                        second <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a 1-cycle-latency synchronous FIFO and re-presents the words as a valid/ready stream.
// Optional word/stall statistics counters are built when FIFO_STREAM_READER_STATS_EN is defined.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic              fifo_underflow,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              err_underflow,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic             inflight;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   pending;

    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;
    // Slots still claimed after this edge; a read is only issued if one slot remains free.
    assign pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (en) state_nxt = ACTIVE;
            ACTIVE:   if (!en) state_nxt = STOPPING;
            STOPPING: begin
                if (en)                               state_nxt = ACTIVE;
                else if (!inflight && (occ == '0))    state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        busy       = (state != IDLE);
        if (state == ACTIVE)
            fifo_rd_en = !fifo_empty && (pending < (OCC_W + 1)'(BUF_DEPTH));
    end

    // Read-latency stage: fifo_data_out is valid the cycle after the pop request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= 1'b0;
        else        inflight <= fifo_rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              err_underflow <= 1'b0;
        else if (fifo_underflow) err_underflow <= 1'b1;
    end

    fifo_stream_reader_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .din   (fifo_data_out),
        .occ   (occ),
        .head  (m_data)
    );

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [CNT_W-1:0] word_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_r  <= '0;
            stall_cnt_r <= '0;
        end else begin
            if (pop)                  word_cnt_r  <= sat_inc(word_cnt_r);
            if (m_valid && !m_ready)  stall_cnt_r <= sat_inc(stall_cnt_r);
        end
    end

    assign word_cnt  = word_cnt_r;
    assign stall_cnt = stall_cnt_r;
`else
    assign word_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's synchronous FIFO.
- Drives the FIFO's rd_en/empty/data_out port, which has 1-cycle read latency.
- Re-presents the popped words as a valid/ready stream to downstream logic, sustaining 1 word/clk with no FIFO underflow.
- Sits directly between the FIFO's read port and a stream sink, with a start/stop control from the host FSM.

Parameters:
- DATA_W, 16, word width; must equal the FIFO's FIFO_WIDTH.
- CNT_W, 32, width of the optional statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  run request from the host FSM.
- fifo_empty  in  1  FIFO empty flag.
- fifo_underflow  in  1  FIFO underflow flag.
- fifo_data_out  in  DATA_W  FIFO read data, valid the cycle after rd_en is sampled.
- fifo_rd_en  out  1  FIFO pop request.
- m_valid  out  1  stream word valid.
- m_ready  in  1  sink accepts word.
- m_data  out  DATA_W  stream word.
- busy  out  1  state != IDLE.
- err_underflow  out  1  sticky protocol error.
- word_cnt  out  CNT_W  words delivered (optional feature).
- stall_cnt  out  CNT_W  backpressure cycles (optional feature).

Behaviour:
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, busy=0, err_underflow=0, counters=0. State=IDLE, inflight=0, occ=0, buffer contents=0.
- Reset mid-operation: all of the above clear immediately. In-flight words are discarded and are not delivered.
- Output buffer: 2-entry FIFO, occ in 0..2.
  - m_valid = (occ != 0).
  - m_data = head entry, driven from a register.
  - pop = m_valid & m_ready.
- inflight: register equal to fifo_rd_en from the previous cycle.
  - When inflight=1, fifo_data_out is captured into the buffer tail at this edge.
- Issue rule (combinational from registered state, fifo_empty and m_ready): fifo_rd_en = (state==ACTIVE) & !fifo_empty & (occ + inflight - pop < 2).
  - Guarantees no buffer overflow and no FIFO underflow.
  - Sustained throughput is 1 word/clk while the FIFO is non-empty and m_ready=1.
- Latency: a word is popped at edge N, captured at edge N+1, and m_valid is high after N+1. Total: 2 cycles from rd_en to m_valid.
- Capture and pop in the same edge: occ is unchanged, head advances, ordering is preserved.
- If occ=0, inflight=1 and pop=0, the word is captured and appears on m_data next cycle. No combinational bypass.
- FSM transitions:
  - IDLE: en=1 -> ACTIVE.
  - ACTIVE: issues reads; en=0 -> STOPPING.
  - STOPPING: no new reads. en=1 -> ACTIVE. Otherwise, when inflight=0 & occ=0 -> IDLE.
- Buffered words are always delivered before IDLE. en=0 never drops data.
- Backpressure: m_valid and m_data are held stable while m_valid & !m_ready.
- err_underflow: set when fifo_underflow=1 is sampled at any edge; cleared only by rst_n.
- FIFO empty while ACTIVE: fifo_rd_en=0, and the block stays ACTIVE waiting for data.

Optional Feature:
- Macro: FIFO_STREAM_READER_STATS_EN.
- Defined:
  - word_cnt increments on each pop.
  - stall_cnt increments each cycle with m_valid & !m_ready.
  - Both saturate at all-ones and clear on reset only.
- Undefined: word_cnt and stall_cnt are tied to 0 and no counter logic is generated. The port list is identical in both builds.

Decomposition:
- Package fifo_stream_reader_pkg holds:
  - state_t enum {IDLE, ACTIVE, STOPPING}.
  - localparam BUF_DEPTH=2.
  - localparam OCC_W=2.
- One sub-module: fifo_stream_reader_buf, the 2-entry buffer with push/pop/occ/head outputs, parameterised by DATA_W.

Test Plan:
- Throughput: preload the FIFO with 8 words 0x0001..0x0008, en=1, m_ready=1. Expect:
  - fifo_rd_en high for 8 consecutive cycles.
  - m_data 0x0001..0x0008 on 8 consecutive cycles, first m_valid 2 cycles after the first rd_en.
  - err_underflow=0.
- Backpressure: 4 words, m_ready toggling 1,0,0,1,... Expect:
  - All 4 words delivered in order.
  - m_data stable during stalls; occ never exceeds 2.
  - fifo_rd_en low whenever occ+inflight-pop = 2.
  - stall_cnt equals the number of stalled valid cycles (STATS build).
- Empty FIFO: en=1 with the FIFO empty for 10 cycles. Expect fifo_rd_en=0 throughout, m_valid=0, busy=1, err_underflow=0.
- Stop with data in flight:
  - Setup: 6 words, m_ready=0; drop en after 3 cycles.
  - While m_ready=0: state STOPPING, no further rd_en.
  - After m_ready=1: the 2 buffered words drain, then busy=0 and 4 words remain in the FIFO.
- Reset mid-stream: assert rst_n=0 while occ=2. Expect m_valid=0, fifo_rd_en=0, busy=0 immediately, with no glitch words delivered after release.
- Error flag: force fifo_underflow=1 for 1 cycle. Expect err_underflow=1, held until rst_n.
